// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: 2-flop synchronizer, prescaled tick generator,
// 2-of-3 majority vote per bit, valid/ready byte output with framing/overrun pulses.
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 35,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int PW = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
  localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [OW-1:0] T_S0     = OW'(OVERSAMPLE/2 - 1);
  localparam logic [OW-1:0] T_S1     = OW'(OVERSAMPLE/2);
  localparam logic [OW-1:0] T_DEC    = OW'(OVERSAMPLE/2 + 1);
  localparam logic [OW-1:0] T_END    = OW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                state, state_n;
  logic                  rx_meta, rxs;
  logic [PW-1:0]         pre_cnt;
  logic [OW-1:0]         tick_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  s0, s1;
  logic                  tick, decide, bit_end, vote, stop_ok, stop_bad;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign tick     = (state != S_IDLE) && (pre_cnt == PRE_LAST);
  assign decide   = tick && (tick_cnt == T_DEC);
  assign bit_end  = tick && (tick_cnt == T_END);
  assign vote     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign stop_ok  = (state == S_STOP) && decide && vote;
  assign stop_bad = (state == S_STOP) && decide && !vote;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!rxs) state_n = S_START;
      S_START: begin
        if (decide && vote) state_n = S_IDLE;
        else if (bit_end)   state_n = S_DATA;
      end
      S_DATA:  if (bit_end && (bit_idx == IDX_LAST)) state_n = S_STOP;
      // Leaving mid-stop-bit lets a back-to-back start edge be caught in IDLE.
      S_STOP:  if (decide) state_n = vote ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        pre_cnt  <= '0;
        tick_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
        if (state == S_DATA && bit_end) bit_idx <= bit_idx + 1'b1;
      end
      if (tick && tick_cnt == T_S0) s0 <= rxs;
      if (tick && tick_cnt == T_S1) s1 <= rxs;
      if (state == S_DATA && decide) shreg <= {vote, shreg[DATA_WIDTH-1:1]};
    end
  end

  // A finished byte loads if the slot is free or being drained this cycle; otherwise it is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_data_o    <= '0;
      m_valid_o   <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= stop_ok && m_valid_o && !m_ready_i;
      if (stop_ok && (!m_valid_o || m_ready_i)) begin
        m_data_o  <= shreg;
        m_valid_o <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: frame-level model (expected byte queue and
// pulse counts) checked every cycle, plus directed corner cases and random bytes.
module tb_uart_rx_os;

  localparam int BIT_CLK = 280;
  localparam int LAT     = 2733;
  localparam int LAT_TOL = 35;

  logic       clk_i = 1'b0;
  logic       rst_ni, rx_i, m_ready_i;
  logic [7:0] m_data_o;
  logic       m_valid_o, frame_err_o, overrun_o;

  uart_rx_os #(.DATA_WIDTH(8), .PRESCALE(35), .OVERSAMPLE(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #15 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0, seen_ferr = 0, seen_ovr = 0;
  int         t_start = 0;
  bit         lat_arm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  logic       p_valid = 0, p_ready = 0, p_rst = 0;
  logic [7:0] p_data = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("reset_outputs", {22'd0, m_valid_o, m_data_o, frame_err_o, overrun_o}, 32'd0);
    end else begin
      if (p_rst && p_valid && !p_ready) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, p_data);
      end
      if (p_rst && p_valid && p_ready) chk("valid_drop", m_valid_o, 0);
      if (lat_arm && m_valid_o && !p_valid) begin
        int d;
        lat_arm = 0;
        d = cyc - t_start;
        n_cmp++;
        if (d < LAT - LAT_TOL || d > LAT + LAT_TOL) begin
          n_bad++;
          $display("FAIL latency: got %0d want %0d+-%0d", d, LAT, LAT_TOL);
        end
      end
      if (m_valid_o && m_ready_i) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rx_byte", m_data_o, exp_q.pop_front());
      end
      if (frame_err_o) seen_ferr++;
      if (overrun_o)   seen_ovr++;
      if (frame_err_o || overrun_o) chk("pulse_exclusive", frame_err_o & overrun_o, 0);
    end
    p_valid = m_valid_o; p_ready = m_ready_i; p_data = m_data_o; p_rst = rst_ni;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Drives one frame; gbit/gs/gl invert a window of one bit, rbit aborts with a reset.
  task automatic send(input logic [7:0] d, input bit stop_v, input int gbit,
                      input int gs, input int gl, input int rbit);
    logic [9:0] fr;
    fr = {stop_v, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        if (b == rbit && c == 100) begin
          rst_ni = 1'b0;
          rx_i   = 1'b1;
          idle(3);
          rst_ni = 1'b1;
          return;
        end
        rx_i = fr[b] ^ ((b == gbit && c >= gs && c < gs + gl) ? 1'b1 : 1'b0);
        if (b == 0 && c == 0) t_start = cyc;
        @(posedge clk_i); #1;
      end
    end
  endtask

  task automatic phase_check();
    chk("missing_bytes", exp_q.size(), 0);
    chk("ferr_count", seen_ferr, exp_ferr);
    chk("ovr_count", seen_ovr, exp_ovr);
  endtask

  initial begin
    rst_ni = 1'b0; rx_i = 1'b1; m_ready_i = 1'b1;
    idle(3);
    chk("reset_valid", m_valid_o, 0);
    chk("reset_data", m_data_o, 0);
    rst_ni = 1'b1;
    idle(20);

    // Single byte, ready tied high, latency window.
    lat_arm = 1;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1, -1, 0, 0, -1);
    idle(50);
    chk("latency_seen", lat_arm, 0);
    phase_check();

    // Back-to-back with consumer stalled: first byte kept, two overruns.
    m_ready_i = 1'b0;
    exp_q.push_back(8'h00);
    exp_ovr += 2;
    send(8'h00, 1, -1, 0, 0, -1);
    send(8'hFF, 1, -1, 0, 0, -1);
    send(8'h55, 1, -1, 0, 0, -1);
    idle(50);
    chk("stall_valid", m_valid_o, 1);
    chk("stall_data", m_data_o, 8'h00);
    chk("stall_ovr", seen_ovr, exp_ovr);
    m_ready_i = 1'b1;
    idle(1);
    m_ready_i = 1'b0;
    idle(1);
    chk("drain_valid", m_valid_o, 0);
    chk("drain_data", m_data_o, 8'h00);
    m_ready_i = 1'b1;
    idle(20);
    phase_check();

    // Bad stop bit, line held low, then a clean frame.
    exp_ferr++;
    send(8'h3C, 0, -1, 0, 0, -1);
    rx_i = 1'b0;
    idle(1000);
    rx_i = 1'b1;
    idle(300);
    phase_check();
    exp_q.push_back(8'h3C);
    send(8'h3C, 1, -1, 0, 0, -1);
    idle(50);
    phase_check();

    // Short low glitch is a false start.
    rx_i = 1'b0;
    idle(100);
    rx_i = 1'b1;
    idle(400);
    phase_check();
    exp_q.push_back(8'h81);
    send(8'h81, 1, -1, 0, 0, -1);
    idle(50);
    phase_check();

    // One-tick inversion around the middle sample of data bit 3 is outvoted.
    exp_q.push_back(8'h0F);
    send(8'h0F, 1, 4, 158, 35, -1);
    idle(50);
    phase_check();

    // Reset during data bit 4 aborts the frame.
    send(8'hC3, 1, -1, 0, 0, 5);
    rx_i = 1'b1;
    idle(300);
    phase_check();
    exp_q.push_back(8'h81);
    send(8'h81, 1, -1, 0, 0, -1);
    idle(50);
    phase_check();

    // Random bytes with random gaps, some back-to-back.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      int         gap;
      b   = 8'($urandom);
      gap = (i % 3 == 0) ? 0 : int'($urandom_range(0, 300));
      exp_q.push_back(b);
      send(b, 1, -1, 0, 0, -1);
      idle(gap);
    end
    idle(50);
    phase_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receiver for the FPGA ALU/UART datapath. It converts the serial rx_i line (8N1, LSB first, idle high) into parallel bytes and presents them on a valid/ready output for the command decoder or ALU front-end. It is the design-side partner of the bench's byte driver, which holds each bit for 280 clocks at 32.256 MHz. It reports framing errors and output overruns as one-cycle pulses.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE, 35, clk_i cycles per oversample tick
OVERSAMPLE, 8, ticks per bit. Bit period = PRESCALE*OVERSAMPLE = 280 clocks at the defaults.

Ports:
clk_i  input  1  system clock, 32.256 MHz nominal
rst_ni  input  1  reset, asynchronous assert, active-low
rx_i  input  1  serial line, asynchronous to clk_i, idle high
m_data_o  output  DATA_WIDTH  received byte
m_valid_o  output  1  m_data_o holds an unconsumed byte
m_ready_i  input  1  consumer accepts the byte when high together with m_valid_o
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: a byte completed while the output was still occupied

Behaviour:
- Interface: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: m_data_o=0, m_valid_o=0, frame_err_o=0, overrun_o=0, FSM=IDLE, all counters 0. Both synchronizer flops reset to 1.
- Synchronizer: rx_i passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick generator: prescale counter 0..PRESCALE-1, running only outside IDLE. A tick fires on wrap. The tick counter counts 0..OVERSAMPLE-1 within each bit.
- Majority vote: rxs is sampled on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is the 2-of-3 majority, taken on tick OVERSAMPLE/2+1.
- FSM states:
  - IDLE: on rxs==0, clear both counters and go to START.
  - START: at the decision, vote 1 means a false start; return to IDLE with no pulse. Vote 0 means continue: at the end of the bit go to DATA with bit index 0.
  - DATA: shift the vote into the shift register LSB-first. After bit DATA_WIDTH-1, go to STOP at the end of the bit.
  - STOP: at the decision, vote 1 means a good frame and the byte is delivered; go straight to IDLE mid-stop-bit. Vote 0 means frame_err_o pulses for 1 cycle, the byte is discarded, and the FSM goes to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. A low held line never produces further frames or errors.
- Delivery (cycle after the stop decision):
  - If m_valid_o==0, or m_valid_o&&m_ready_i in that cycle: load m_data_o and set m_valid_o=1.
  - If m_valid_o&&!m_ready_i: drop the new byte, keep the old one, pulse overrun_o for 1 cycle.
- Handshake:
  - m_valid_o stays high, and m_data_o stays stable, until a cycle with m_ready_i=1. m_valid_o clears the following cycle unless a new byte loads in that same cycle.
  - m_ready_i may be high permanently.
  - m_valid_o does not depend combinationally on m_ready_i.
- Latency: m_valid_o rises 2 + 9*PRESCALE*OVERSAMPLE + (OVERSAMPLE/2+2)*PRESCALE + 1 clocks after the first rx_i low edge, ±PRESCALE. At the defaults this is 2733±35.
- Back-to-back frames: a new start bit may begin immediately after the stop bit with no idle gap. It is detected because the FSM returns to IDLE mid-stop.
- Reset mid-frame: the FSM aborts immediately and all outputs go to reset values. A partially received frame never produces m_valid_o, frame_err_o or overrun_o.
- frame_err_o and overrun_o are never asserted in the same cycle.

Test Plan:
- Bench sends 0xA5 at 280 clk/bit with m_ready_i=1 -> m_data_o=0xA5, m_valid_o high for exactly 1 cycle within 2733±35 clocks of the start edge, no error pulses.
- Bench sends back-to-back 0x00, 0xFF, 0x55 with m_ready_i=0 -> 0x00 is held on m_data_o. overrun_o pulses twice. After m_ready_i=1 for 1 cycle, m_valid_o drops and m_data_o stays 0x00.
- Frame 0x3C sent with the stop bit driven 0, then rx held low 1000 clocks, then high, then 0x3C sent correctly -> exactly one frame_err_o pulse, no m_valid_o for the first frame, then m_data_o=0x3C.
- rx_i pulsed low for 100 clocks, then idle -> no m_valid_o and no frame_err_o. A following 0x81 is received correctly.
- rx_i inverted for 35 clocks centred on tick OVERSAMPLE/2 of bit 3 of 0x0F -> majority vote still yields m_data_o=0x0F.
- rst_ni asserted for 3 clocks during data bit 4 of 0xC3 -> all outputs 0 immediately, no output for the aborted frame. The next frame 0x81 delivers m_data_o=0x81.
